// File: rtl/matmul_host_sequencer_if.sv
// Host-side bundle of the matrix multiplier sequencer: command, element streams,
// A/B write ports, C read port and the control_path start/done handshake.
interface matmul_host_sequencer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  cmd_start;
  logic                  busy;
  logic                  job_done;

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;

  logic                  en_WriteMat_A;
  logic [3:0]            rowAddr_A;
  logic [3:0]            colAddr_A;
  logic [DATA_WIDTH-1:0] writeData_A;

  logic                  en_WriteMat_B;
  logic [3:0]            rowAddr_B;
  logic [3:0]            colAddr_B;
  logic [DATA_WIDTH-1:0] writeData_B;

  logic                  mul_start;
  logic                  mul_done;

  logic                  en_ReadMat_C;
  logic [3:0]            rowAddr_C;
  logic [3:0]            colAddr_C;
  logic [DATA_WIDTH-1:0] readData_C;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    input  cmd_start, in_valid, in_data, mul_done, readData_C, out_ready,
    output busy, job_done, in_ready,
    output en_WriteMat_A, rowAddr_A, colAddr_A, writeData_A,
    output en_WriteMat_B, rowAddr_B, colAddr_B, writeData_B,
    output mul_start, en_ReadMat_C, rowAddr_C, colAddr_C,
    output out_valid, out_data
  );

  modport slave (
    output cmd_start, in_valid, in_data, mul_done, readData_C, out_ready,
    input  busy, job_done, in_ready,
    input  en_WriteMat_A, rowAddr_A, colAddr_A, writeData_A,
    input  en_WriteMat_B, rowAddr_B, colAddr_B, writeData_B,
    input  mul_start, en_ReadMat_C, rowAddr_C, colAddr_C,
    input  out_valid, out_data
  );
endinterface

// File: rtl/matmul_host_sequencer.sv
// Job sequencer: loads A then B from the host stream, kicks control_path,
// waits for completion, then drains C out over a valid/ready stream.
module matmul_host_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 4
) (
  input  logic clk,
  input  logic reset_n,
  matmul_host_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_START,
    S_WAIT,
    S_C_RD,
    S_C_CAP,
    S_C_OUT
  } state_t;

  localparam logic [3:0] LAST = 4'(N - 1);

  state_t                r_state;
  logic [3:0]            r_row;
  logic [3:0]            r_col;
  logic [DATA_WIDTH-1:0] r_outData;
  logic                  r_busy;
  logic                  r_inReady;
  logic                  r_mulStart;
  logic                  r_enReadC;
  logic                  r_outValid;
  logic                  r_jobDone;

  logic                  w_loadA;
  logic                  w_loadB;
  logic                  w_accept;
  logic                  w_lastElem;

  assign w_loadA    = (r_state == S_LOAD_A);
  assign w_loadB    = (r_state == S_LOAD_B);
  assign w_accept   = bus.in_valid && r_inReady;
  assign w_lastElem = (r_row == LAST) && (r_col == LAST);

  // Write enables follow the handshake combinationally so a streamed element
  // lands in memory in the same cycle it is accepted.
  assign bus.en_WriteMat_A = w_accept && w_loadA;
  assign bus.rowAddr_A     = w_loadA ? r_row : 4'd0;
  assign bus.colAddr_A     = w_loadA ? r_col : 4'd0;
  assign bus.writeData_A   = w_loadA ? bus.in_data : '0;

  assign bus.en_WriteMat_B = w_accept && w_loadB;
  assign bus.rowAddr_B     = w_loadB ? r_row : 4'd0;
  assign bus.colAddr_B     = w_loadB ? r_col : 4'd0;
  assign bus.writeData_B   = w_loadB ? bus.in_data : '0;

  assign bus.en_ReadMat_C  = r_enReadC;
  assign bus.rowAddr_C     = r_enReadC ? r_row : 4'd0;
  assign bus.colAddr_C     = r_enReadC ? r_col : 4'd0;

  assign bus.busy          = r_busy;
  assign bus.job_done      = r_jobDone;
  assign bus.in_ready      = r_inReady;
  assign bus.mul_start     = r_mulStart;
  assign bus.out_valid     = r_outValid;
  assign bus.out_data      = r_outData;

  // Output flags are computed alongside the next state so each is a flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_row      <= 4'd0;
      r_col      <= 4'd0;
      r_outData  <= '0;
      r_busy     <= 1'b0;
      r_inReady  <= 1'b0;
      r_mulStart <= 1'b0;
      r_enReadC  <= 1'b0;
      r_outValid <= 1'b0;
      r_jobDone  <= 1'b0;
    end else begin
      r_mulStart <= 1'b0;
      r_enReadC  <= 1'b0;
      r_jobDone  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_start) begin
            r_state   <= S_LOAD_A;
            r_row     <= 4'd0;
            r_col     <= 4'd0;
            r_busy    <= 1'b1;
            r_inReady <= 1'b1;
          end
        end
        S_LOAD_A, S_LOAD_B: begin
          if (w_accept) begin
            if (w_lastElem) begin
              r_row <= 4'd0;
              r_col <= 4'd0;
              if (w_loadA) begin
                r_state <= S_LOAD_B;
              end else begin
                r_state    <= S_START;
                r_inReady  <= 1'b0;
                r_mulStart <= 1'b1;
              end
            end else if (r_col == LAST) begin
              r_col <= 4'd0;
              r_row <= r_row + 4'd1;
            end else begin
              r_col <= r_col + 4'd1;
            end
          end
        end
        S_START: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.mul_done) begin
            r_state   <= S_C_RD;
            r_row     <= 4'd0;
            r_col     <= 4'd0;
            r_enReadC <= 1'b1;
          end
        end
        S_C_RD: begin
          r_state <= S_C_CAP;
        end
        S_C_CAP: begin
          r_outData  <= bus.readData_C;
          r_outValid <= 1'b1;
          r_state    <= S_C_OUT;
        end
        S_C_OUT: begin
          if (bus.out_ready) begin
            r_outValid <= 1'b0;
            if (w_lastElem) begin
              r_state   <= S_IDLE;
              r_busy    <= 1'b0;
              r_jobDone <= 1'b1;
            end else begin
              r_state   <= S_C_RD;
              r_enReadC <= 1'b1;
              if (r_col == LAST) begin
                r_col <= 4'd0;
                r_row <= r_row + 4'd1;
              end else begin
                r_col <= r_col + 4'd1;
              end
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_host_sequencer.sv
// Directed bench for matmul_host_sequencer: an N=4 instance for the main jobs
// and an N=2 instance for the smallest-matrix boundary.
module tb_matmul_host_sequencer;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst4_n;
  logic rst2_n;

  always #5 clk = ~clk;

  matmul_host_sequencer_if #(.DATA_WIDTH(DW)) if4 ();
  matmul_host_sequencer_if #(.DATA_WIDTH(DW)) if2 ();

  matmul_host_sequencer #(.DATA_WIDTH(DW), .N(4)) u_dut4 (
    .clk     (clk),
    .reset_n (rst4_n),
    .bus     (if4.master)
  );

  matmul_host_sequencer #(.DATA_WIDTH(DW), .N(2)) u_dut2 (
    .clk     (clk),
    .reset_n (rst2_n),
    .bus     (if2.master)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] aLog[$];
  logic [15:0] bLog[$];
  logic [7:0]  outLog[$];
  logic [15:0] aLog2[$];
  logic [15:0] bLog2[$];
  logic [7:0]  outLog2[$];
  int mulStarts  = 0;
  int cReads     = 0;
  int jobDones   = 0;
  int mulStarts2 = 0;
  int jobDones2  = 0;

  // C memory model: each location holds row*16+col, one cycle read latency.
  always @(posedge clk) begin
    if (if4.en_ReadMat_C) if4.readData_C <= {if4.rowAddr_C, if4.colAddr_C};
    if (if2.en_ReadMat_C) if2.readData_C <= {if2.rowAddr_C, if2.colAddr_C};
  end

  // Mid-cycle monitors log every write, read, pulse and output handshake.
  always @(negedge clk) begin
    if (if4.en_WriteMat_A) aLog.push_back({if4.rowAddr_A, if4.colAddr_A, if4.writeData_A});
    if (if4.en_WriteMat_B) bLog.push_back({if4.rowAddr_B, if4.colAddr_B, if4.writeData_B});
    if (if4.mul_start) mulStarts++;
    if (if4.en_ReadMat_C) cReads++;
    if (if4.job_done) jobDones++;
    if (if4.out_valid && if4.out_ready) outLog.push_back(if4.out_data);
    if (if2.en_WriteMat_A) aLog2.push_back({if2.rowAddr_A, if2.colAddr_A, if2.writeData_A});
    if (if2.en_WriteMat_B) bLog2.push_back({if2.rowAddr_B, if2.colAddr_B, if2.writeData_B});
    if (if2.mul_start) mulStarts2++;
    if (if2.job_done) jobDones2++;
    if (if2.out_valid && if2.out_ready) outLog2.push_back(if2.out_data);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d);
    if4.in_valid = v;
    if4.in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic startJob4();
    if4.cmd_start = 1'b1;
    @(posedge clk);
    #1;
    if4.cmd_start = 1'b0;
    checkOutput("busyRise", 32'(if4.busy), 32'd1);
    checkOutput("inReadyRise", 32'(if4.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    logic [7:0] bData;

    if4.cmd_start = 1'b0; if4.in_valid = 1'b1; if4.in_data = 8'hA5;
    if4.mul_done  = 1'b0; if4.out_ready = 1'b0;
    if2.cmd_start = 1'b0; if2.in_valid = 1'b0; if2.in_data = 8'h00;
    if2.mul_done  = 1'b0; if2.out_ready = 1'b0;
    rst4_n = 1'b0;
    rst2_n = 1'b0;

    #12;
    checkOutput("rstBusy", 32'(if4.busy), 32'd0);
    checkOutput("rstInReady", 32'(if4.in_ready), 32'd0);
    checkOutput("rstWrA", 32'(if4.en_WriteMat_A), 32'd0);
    checkOutput("rstMulStart", 32'(if4.mul_start), 32'd0);
    checkOutput("rstRdC", 32'(if4.en_ReadMat_C), 32'd0);
    checkOutput("rstOutValid", 32'(if4.out_valid), 32'd0);
    checkOutput("rstOutData", 32'(if4.out_data), 32'd0);
    checkOutput("rstJobDone", 32'(if4.job_done), 32'd0);
    if4.in_valid = 1'b0;
    @(negedge clk);
    rst4_n = 1'b1;
    rst2_n = 1'b1;
    @(posedge clk);
    #1;

    // Gapped load of A and six B elements, then reset in the middle of LOAD_B.
    startJob4();
    for (int i = 0; i < 22; i++) begin
      applyStimulus(1'b1, 8'(64 + i));
      applyStimulus(1'b0, 8'hEE);
    end
    checkOutput("gapACount", 32'(aLog.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("gapA%0d", i), 32'(aLog[i]), 32'({4'(i / 4), 4'(i % 4), 8'(64 + i)}));
    checkOutput("gapBCount", 32'(bLog.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("gapB%0d", i), 32'(bLog[i]), 32'({4'(i / 4), 4'(i % 4), 8'(80 + i)}));

    if4.in_valid = 1'b1;
    if4.in_data  = 8'h99;
    #2;
    rst4_n = 1'b0;
    #1;
    checkOutput("midRstWrB", 32'(if4.en_WriteMat_B), 32'd0);
    checkOutput("midRstBusy", 32'(if4.busy), 32'd0);
    checkOutput("midRstInReady", 32'(if4.in_ready), 32'd0);
    checkOutput("midRstAddrB", 32'({if4.rowAddr_B, if4.colAddr_B}), 32'd0);
    checkOutput("midRstDataB", 32'(if4.writeData_B), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("midRstNoWrites", 32'(bLog.size()), 32'd6);
    if4.in_valid = 1'b0;
    rst4_n = 1'b1;
    @(posedge clk);
    #1;

    // Fresh full job with ignored mul_done in LOAD_A and cmd_start in LOAD_B.
    aLog.delete(); bLog.delete(); outLog.delete();
    mulStarts = 0; cReads = 0; jobDones = 0;
    startJob4();
    for (int i = 0; i < 32; i++) begin
      if4.mul_done  = (i == 3);
      if4.cmd_start = (i == 20);
      bData = (((i - 16) / 4) == ((i - 16) % 4)) ? 8'd1 : 8'd0;
      applyStimulus(1'b1, (i < 16) ? 8'(i + 1) : bData);
    end
    if4.mul_done  = 1'b0;
    if4.cmd_start = 1'b0;
    checkOutput("mulStartPulse", 32'(if4.mul_start), 32'd1);
    checkOutput("inReadyDrop", 32'(if4.in_ready), 32'd0);
    if4.in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mulStartDrop", 32'(if4.mul_start), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    checkOutput("noEarlyDrain", 32'(cReads), 32'd0);
    checkOutput("busyInWait", 32'(if4.busy), 32'd1);
    checkOutput("mulStartCount", 32'(mulStarts), 32'd1);
    checkOutput("fullACount", 32'(aLog.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("fullA%0d", i), 32'(aLog[i]), 32'({4'(i / 4), 4'(i % 4), 8'(i + 1)}));
    checkOutput("fullBCount", 32'(bLog.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("fullB%0d", i), 32'(bLog[i]),
                  32'({4'(i / 4), 4'(i % 4), ((i / 4) == (i % 4)) ? 8'd1 : 8'd0}));

    if4.mul_done = 1'b1;
    @(posedge clk);
    #1;
    if4.mul_done = 1'b0;
    checkOutput("readAfterDone", 32'(if4.en_ReadMat_C), 32'd1);
    checkOutput("firstReadAddr", 32'({if4.rowAddr_C, if4.colAddr_C}), 32'd0);

    if4.out_ready = 1'b1;
    for (int idx = 0; idx < 16; idx++) begin
      if4.out_ready = (idx != 3);
      cnt = 0;
      while (!if4.out_valid && cnt < 20) begin
        @(posedge clk);
        #1;
        cnt++;
      end
      if (cnt >= 20) checkOutput($sformatf("validTimeout%0d", idx), 32'd0, 32'd1);
      if (idx == 3) begin
        for (int k = 0; k < 5; k++) begin
          @(posedge clk);
          #1;
          checkOutput("bpValid", 32'(if4.out_valid), 32'd1);
          checkOutput("bpData", 32'(if4.out_data), 32'h03);
        end
        checkOutput("bpNoRead", 32'(cReads), 32'd4);
        if4.out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("jobDonePulse", 32'(if4.job_done), 32'd1);
    checkOutput("busyFall", 32'(if4.busy), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("jobDoneDrop", 32'(if4.job_done), 32'd0);
    checkOutput("outCount", 32'(outLog.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("out%0d", i), 32'(outLog[i]), 32'({4'(i / 4), 4'(i % 4)}));
    checkOutput("jobDoneCount", 32'(jobDones), 32'd1);
    checkOutput("cReadCount", 32'(cReads), 32'd16);
    if4.out_ready = 1'b0;

    // N=2 boundary: wrap at col 1, A->B after 4th accept, 3*N*N drain latency.
    if2.cmd_start = 1'b1;
    @(posedge clk);
    #1;
    if2.cmd_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if2.in_valid = 1'b1;
      if2.in_data  = 8'(i + 1);
      @(posedge clk);
      #1;
      if (i == 3) begin
        checkOutput("n2ACountAt4", 32'(aLog2.size()), 32'd4);
        checkOutput("n2BEmptyAt4", 32'(bLog2.size()), 32'd0);
      end
    end
    if2.in_valid = 1'b0;
    checkOutput("n2MulStart", 32'(if2.mul_start), 32'd1);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("n2A%0d", i), 32'(aLog2[i]), 32'({4'(i / 2), 4'(i % 2), 8'(i + 1)}));
      checkOutput($sformatf("n2B%0d", i), 32'(bLog2[i]), 32'({4'(i / 2), 4'(i % 2), 8'(i + 5)}));
    end
    repeat (3) @(posedge clk);
    #1;
    if2.out_ready = 1'b1;
    if2.mul_done  = 1'b1;
    @(posedge clk);
    #1;
    if2.mul_done = 1'b0;
    cnt = 0;
    while (!if2.job_done && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    checkOutput("n2JobDoneLatency", 32'(cnt), 32'd12);
    checkOutput("n2BusyFall", 32'(if2.busy), 32'd0);
    checkOutput("n2OutCount", 32'(outLog2.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("n2Out%0d", i), 32'(outLog2[i]), 32'({4'(i / 2), 4'(i % 2)}));
    @(posedge clk);
    #1;
    checkOutput("n2JobDoneCount", 32'(jobDones2), 32'd1);
    checkOutput("n2MulStartCount", 32'(mulStarts2), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
